// File: rtl/pulse_sync_pkg.sv
// Purpose: shared types and default constants for the toggle-handshake event crossing.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pulse_sync_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } hs_state_e;

  localparam int SYNC_STAGES_DEF = 3;
  localparam int CNT_W_DEF       = 4;
  localparam int TIMEOUT_DEF     = 1024;

endpackage

// File: rtl/pulse_sync_tx_bit_sync_chain.sv
// Purpose: N-flop single-bit synchronizer (module bit_sync_chain), async active-low reset to 0.
// Latency: N clk_i edges from d_i to q_o.
// Backpressure: none; a pure delay line for a level signal.
// Ports: clk_i clock, rst_n_i async active-low reset, d_i async input bit, q_o synchronized bit.
module bit_sync_chain
  import pulse_sync_pkg::*;
#(
  parameter int N = SYNC_STAGES_DEF
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[N-2:0], d_i};
    end
  end

  assign q_o = sync_q[N-1];

endmodule

// File: rtl/pulse_sync_tx.sv
// Purpose: transmit end of a toggle-handshake event crossing; queues event pulses and launches each as a req toggle.
// Latency: pulse_in at edge N flips req_toggle_out after edge N+1 when idle; next launch waits for the synchronized ack.
// Backpressure: bursts queue in a saturating pending counter; a pulse arriving when the queue is full is dropped (overflow_err).
// Ports: clk_out clock, rst_n_in async active-low reset, pulse_in event strobe, ack_toggle_in async ack toggle,
//        clr_err sticky-flag clear, req_toggle_out req toggle, busy handshake outstanding, pending_cnt queued events,
//        overflow_err / timeout_err sticky flags, sent_cnt completed handshakes.
// Build option: define PULSE_SYNC_TX_STATS_EN to enable sent_cnt; otherwise it is tied to zero.
module pulse_sync_tx
  import pulse_sync_pkg::*;
#(
  parameter int SYNC_STAGES    = SYNC_STAGES_DEF,
  parameter int CNT_W          = CNT_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic             clk_out,
  input  logic             rst_n_in,
  input  logic             pulse_in,
  input  logic             ack_toggle_in,
  input  logic             clr_err,
  output logic             req_toggle_out,
  output logic             busy,
  output logic [CNT_W-1:0] pending_cnt,
  output logic             overflow_err,
  output logic             timeout_err,
  output logic [31:0]      sent_cnt
);

  localparam int               TW        = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]    TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PEND_MAX  = {CNT_W{1'b1}};

  hs_state_e        state_q, state_d;
  logic             req_q, req_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic             ovf_q, ovf_d;
  logic             tmo_q, tmo_d;
  logic             ack_s;
  logic             launch, done;
  logic             pend_nz, pend_inc, pend_dec, ovf_set, tmo_set;

  bit_sync_chain #(.N(SYNC_STAGES)) u_ack_sync (
    .clk_i   (clk_out),
    .rst_n_i (rst_n_in),
    .d_i     (ack_toggle_in),
    .q_o     (ack_s)
  );

  // State register
  always_ff @(posedge clk_out or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (pulse_in || pend_nz) state_d = WAIT_ACK;
      WAIT_ACK: if (ack_s == req_q)      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy   = (state_q == WAIT_ACK);
    launch = (state_q == IDLE) && (pulse_in || pend_nz);
    done   = (state_q == WAIT_ACK) && (ack_s == req_q);
  end

  // Pending queue: while a handshake is outstanding or older events are queued,
  // a new pulse joins the queue; a launch always drains the queue first.
  always_comb begin
    pend_nz  = (pend_q != '0);
    pend_inc = pulse_in && (busy || pend_nz);
    pend_dec = launch && pend_nz;
    ovf_set  = pend_inc && !pend_dec && (pend_q == PEND_MAX);
    pend_d   = pend_q;
    if (pend_inc && !pend_dec && !ovf_set) begin
      pend_d = pend_q + 1'b1;
    end else if (pend_dec && !pend_inc) begin
      pend_d = pend_q - 1'b1;
    end
  end

  // Timeout counter saturates at the threshold so the flag keeps re-asserting
  // (and so survives clr_err) for as long as the ack is still missing.
  always_comb begin
    tmr_d   = tmr_q;
    tmo_set = 1'b0;
    if (busy) begin
      if (done) begin
        tmr_d = '0;
      end else begin
        tmo_set = (tmr_q == TMO_LAST);
        if (tmr_q != TMO_LAST) tmr_d = tmr_q + 1'b1;
      end
    end
  end

  always_comb begin
    req_d = launch ? ~req_q : req_q;
    ovf_d = ovf_set | (ovf_q & ~clr_err);
    tmo_d = tmo_set | (tmo_q & ~clr_err);
  end

  always_ff @(posedge clk_out or negedge rst_n_in) begin
    if (!rst_n_in) begin
      req_q  <= 1'b0;
      pend_q <= '0;
      tmr_q  <= '0;
      ovf_q  <= 1'b0;
      tmo_q  <= 1'b0;
    end else begin
      req_q  <= req_d;
      pend_q <= pend_d;
      tmr_q  <= tmr_d;
      ovf_q  <= ovf_d;
      tmo_q  <= tmo_d;
    end
  end

  assign req_toggle_out = req_q;
  assign pending_cnt    = pend_q;
  assign overflow_err   = ovf_q;
  assign timeout_err    = tmo_q;

`ifdef PULSE_SYNC_TX_STATS_EN
  logic [31:0] sent_q;

  always_ff @(posedge clk_out or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sent_q <= '0;
    end else if (done) begin
      sent_q <= sent_q + 32'd1;
    end
  end

  assign sent_cnt = sent_q;
`else
  assign sent_cnt = 32'd0;
`endif

endmodule
